// File: rtl/mt9v034_frame_ctrl_pkg.sv
// Shared types and constants for the MT9V034 frame capture controller.
package mt9v034_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    PASS     = 2'd2
  } state_t;

  localparam int unsigned ERR_SHORT_LINE = 0;
  localparam int unsigned ERR_LONG_LINE  = 1;
  localparam int unsigned ERR_EARLY_SOF  = 2;
  localparam int unsigned ERR_BITS       = 3;

  localparam int unsigned DEFAULT_WIDTH  = 752;
  localparam int unsigned DEFAULT_HEIGHT = 480;

endpackage

// File: rtl/mt9v034_geom_check.sv
// Column/row counters and line/frame geometry error detection for forwarded beats.
// Optional per-frame statistics under MT9V034_FRAME_CTRL_COUNTERS_EN.
module mt9v034_geom_check
  import mt9v034_pkg::*;
#(
  parameter int unsigned COL_BITS = 11,
  parameter int unsigned ROW_BITS = 10
) (
  input  logic                axi4sclk,
  input  logic                axi4s_reset,
  input  logic                clear,
  input  logic                beat,
  input  logic                in_frame,
  input  logic                sof,
  input  logic                eol,
  input  logic [COL_BITS-1:0] cfg_width,
  input  logic [ROW_BITS-1:0] cfg_height,
  output logic                frame_end,
  output logic [ERR_BITS-1:0] err
`ifdef MT9V034_FRAME_CTRL_COUNTERS_EN
  ,
  output logic [31:0]         frames_ok,
  output logic [31:0]         frames_err
`endif
);

  logic [COL_BITS-1:0] col_q;
  logic [COL_BITS-1:0] base_col;
  logic [ROW_BITS-1:0] row_q;
  logic [ROW_BITS-1:0] base_row;
  logic [ROW_BITS-1:0] last_row;
  logic [COL_BITS:0]   col_inc;
  logic                line_short;
  logic                line_long;
  logic                early_sof;
  logic [ERR_BITS-1:0] err_set;

  // An SOF beat restarts the frame, so all checks use counters as if they were zero.
  always_comb begin
    base_col   = sof ? '0 : col_q;
    base_row   = sof ? '0 : row_q;
    last_row   = cfg_height - ROW_BITS'(1);
    col_inc    = {1'b0, base_col} + (COL_BITS+1)'(1);
    line_short = beat && eol && (col_inc < {1'b0, cfg_width});
    line_long  = beat && eol && (col_inc > {1'b0, cfg_width});
    early_sof  = beat && sof && in_frame && ((col_q != '0) || (row_q != '0));
    frame_end  = beat && eol && (base_row == last_row);
    err_set                 = '0;
    err_set[ERR_SHORT_LINE] = line_short;
    err_set[ERR_LONG_LINE]  = line_long;
    err_set[ERR_EARLY_SOF]  = early_sof;
  end

  always_ff @(posedge axi4sclk or posedge axi4s_reset) begin
    if (axi4s_reset) begin
      col_q <= '0;
      row_q <= '0;
      err   <= '0;
    end else begin
      err <= (clear ? '0 : err) | err_set;
      if (beat) begin
        if (eol) begin
          col_q <= '0;
          row_q <= frame_end ? '0 : base_row + ROW_BITS'(1);
        end else begin
          col_q <= (base_col == '1) ? base_col : base_col + COL_BITS'(1);
          row_q <= base_row;
        end
      end
    end
  end

`ifdef MT9V034_FRAME_CTRL_COUNTERS_EN
  logic frame_err_q;
  logic frame_bad;

  always_comb frame_bad = (sof ? 1'b0 : frame_err_q) | line_short | line_long;

  always_ff @(posedge axi4sclk or posedge axi4s_reset) begin
    if (axi4s_reset) begin
      frame_err_q <= 1'b0;
      frames_ok   <= '0;
      frames_err  <= '0;
    end else begin
      if (beat) begin
        frame_err_q <= frame_end ? 1'b0 : frame_bad;
      end
      if (clear) begin
        frames_ok  <= '0;
        frames_err <= '0;
      end else begin
        if (frame_end && !frame_bad) begin
          frames_ok <= frames_ok + 32'd1;
        end
        frames_err <= frames_err + 32'(early_sof) + 32'(frame_end && frame_bad);
      end
    end
  end
`endif

endmodule

// File: rtl/mt9v034_frame_ctrl.sv
// Frame-level capture gate on the MT9V034 AXI4-Stream output (single-shot/continuous).
// Optional frame statistics outputs under MT9V034_FRAME_CTRL_COUNTERS_EN.
module mt9v034_frame_ctrl
  import mt9v034_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COL_BITS   = 11,
  parameter int unsigned ROW_BITS   = 10
) (
  input  logic                  axi4sclk,
  input  logic                  axi4s_reset,
  input  logic                  ctrl_start,
  input  logic                  ctrl_continuous,
  input  logic                  ctrl_stop,
  input  logic [COL_BITS-1:0]   cfg_width,
  input  logic [ROW_BITS-1:0]   cfg_height,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  status_busy,
  output logic                  status_frame_done,
  output logic [ERR_BITS-1:0]   status_err
`ifdef MT9V034_FRAME_CTRL_COUNTERS_EN
  ,
  output logic [31:0]           frames_ok,
  output logic [31:0]           frames_err
`endif
);

  state_t state_q;
  state_t state_d;
  state_t end_state;
  logic   cont_q;
  logic   stop_pending_q;
  logic   fwd;
  logic   beat;
  logic   frame_end;

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tuser = s_axis_tuser;
  assign m_axis_tlast = s_axis_tlast;
  assign status_busy  = (state_q != IDLE);
  assign beat         = fwd && s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    fwd           = 1'b0;
    end_state     = (cont_q && !stop_pending_q && !ctrl_stop) ? WAIT_SOF : IDLE;
    case (state_q)
      IDLE: begin
        if (ctrl_start && !ctrl_stop) begin
          state_d = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        // A stop here behaves as idle for this cycle so no lone SOF beat leaks downstream.
        if (ctrl_stop) begin
          state_d = IDLE;
        end else if (s_axis_tuser) begin
          fwd           = 1'b1;
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          if (s_axis_tvalid && m_axis_tready) begin
            state_d = frame_end ? end_state : PASS;
          end
        end
      end
      PASS: begin
        fwd           = 1'b1;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        if (frame_end) begin
          state_d = end_state;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi4sclk or posedge axi4s_reset) begin
    if (axi4s_reset) begin
      state_q           <= IDLE;
      cont_q            <= 1'b0;
      stop_pending_q    <= 1'b0;
      status_frame_done <= 1'b0;
    end else begin
      state_q           <= state_d;
      status_frame_done <= frame_end;
      if (state_q == IDLE && ctrl_start && !ctrl_stop) begin
        cont_q <= ctrl_continuous;
      end
      if (state_d == IDLE) begin
        stop_pending_q <= 1'b0;
      end else if (state_q == PASS && ctrl_stop) begin
        stop_pending_q <= 1'b1;
      end
    end
  end

  mt9v034_geom_check #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS)
  ) u_geom (
    .axi4sclk    (axi4sclk),
    .axi4s_reset (axi4s_reset),
    .clear       (ctrl_start),
    .beat        (beat),
    .in_frame    (state_q == PASS),
    .sof         (s_axis_tuser),
    .eol         (s_axis_tlast),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .frame_end   (frame_end),
    .err         (status_err)
`ifdef MT9V034_FRAME_CTRL_COUNTERS_EN
    ,
    .frames_ok   (frames_ok),
    .frames_err  (frames_err)
`endif
  );

endmodule

// File: tb/tb_mt9v034_frame_ctrl.sv
// Directed self-checking bench for mt9v034_frame_ctrl.
module tb_mt9v034_frame_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned CB = 11;
  localparam int unsigned RB = 10;

  logic          axi4sclk = 1'b0;
  logic          axi4s_reset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic          ctrl_continuous = 1'b0;
  logic          ctrl_stop = 1'b0;
  logic [CB-1:0] cfg_width = 11'd752;
  logic [RB-1:0] cfg_height = 10'd2;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          status_busy;
  logic          status_frame_done;
  logic [2:0]    status_err;
`ifdef MT9V034_FRAME_CTRL_COUNTERS_EN
  logic [31:0]   frames_ok;
  logic [31:0]   frames_err;
`endif

  always #5 axi4sclk = ~axi4sclk;

  mt9v034_frame_ctrl #(
    .DATA_WIDTH (DW),
    .COL_BITS   (CB),
    .ROW_BITS   (RB)
  ) dut (
    .axi4sclk          (axi4sclk),
    .axi4s_reset       (axi4s_reset),
    .ctrl_start        (ctrl_start),
    .ctrl_continuous   (ctrl_continuous),
    .ctrl_stop         (ctrl_stop),
    .cfg_width         (cfg_width),
    .cfg_height        (cfg_height),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .status_busy       (status_busy),
    .status_frame_done (status_frame_done),
    .status_err        (status_err)
`ifdef MT9V034_FRAME_CTRL_COUNTERS_EN
    ,
    .frames_ok         (frames_ok),
    .frames_err        (frames_err)
`endif
  );

  int          tests = 0;
  int          failures = 0;
  int          fd_total = 0;
  int          fd0 = 0;
  int          fwd_count = 0;
  int          fwd_user = 0;
  int          seq_err = 0;
  int          mirror_err = 0;
  logic [DW-1:0] exp_col = 16'd1;
  logic        toggle = 1'b0;
  logic        mirror_chk = 1'b0;
  logic        pend_start = 1'b0;
  logic        pend_stop = 1'b0;
  logic        pend_cont = 1'b0;
  logic        acc;

  // frame_done pulses, sampled just after each rising edge
  always begin
    @(posedge axi4sclk);
    #1;
    if (status_frame_done === 1'b1) fd_total++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    fwd_count = 0;
    fwd_user = 0;
    seq_err = 0;
    mirror_err = 0;
    exp_col = 16'd1;
    fd0 = fd_total;
  endtask

  // One clock: drive at the falling edge, observe the handshake before the next rising edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic u, input logic l);
    @(negedge axi4sclk);
    s_axis_tvalid = v;
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    ctrl_start = pend_start;
    ctrl_stop = pend_stop;
    ctrl_continuous = pend_cont;
    pend_start = 1'b0;
    pend_stop = 1'b0;
    m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
    #1;
    acc = v && s_axis_tready;
    if (v && mirror_chk && (s_axis_tready !== m_axis_tready)) mirror_err++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      fwd_count++;
      if (m_axis_tuser === 1'b1) fwd_user++;
      if (m_axis_tdata !== exp_col) seq_err++;
      exp_col = (m_axis_tlast === 1'b1) ? 16'd1 : exp_col + 16'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, u, l);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      tests++;
      failures++;
      $error("FAIL beat_timeout: observed no acceptance after %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic send_line(input int w, input logic sof);
    for (int i = 1; i <= w; i++) send_beat(DW'(i), sof && (i == 1), i == w);
  endtask

  task automatic send_frame(input int w, input int h);
    for (int r = 0; r < h; r++) send_line(w, r == 0);
  endtask

  task automatic pulse_start(input logic cont);
    pend_start = 1'b1;
    pend_cont = cont;
    idle(2);
  endtask

  task automatic pulse_stop();
    pend_stop = 1'b1;
    idle(2);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge axi4sclk);
    check("rst_busy", 32'(status_busy), 0);
    check("rst_err", 32'(status_err), 0);
    check("rst_frame_done", 32'(status_frame_done), 0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_s_tready", 32'(s_axis_tready), 1);
    axi4s_reset = 1'b0;
    idle(2);

    // single shot, 752x2, two frames offered
    cfg_width = 11'd752;
    cfg_height = 10'd2;
    pulse_start(1'b0);
    clear_stats();
    send_frame(752, 2);
    send_frame(752, 2);
    idle(2);
    check("ss_fwd_count", 32'(fwd_count), 1504);
    check("ss_fwd_user", 32'(fwd_user), 1);
    check("ss_seq", 32'(seq_err), 0);
    check("ss_frame_done", 32'(fd_total - fd0), 1);
    check("ss_busy", 32'(status_busy), 0);
    check("ss_err", 32'(status_err), 0);

    // continuous, start lands mid-frame
    cfg_width = 11'd4;
    cfg_height = 10'd3;
    clear_stats();
    send_line(4, 1'b1);
    pulse_start(1'b1);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    send_frame(4, 3);
    send_frame(4, 3);
    idle(2);
    check("cont_fwd_count", 32'(fwd_count), 24);
    check("cont_seq", 32'(seq_err), 0);
    check("cont_frame_done", 32'(fd_total - fd0), 2);
    check("cont_busy", 32'(status_busy), 1);
    check("cont_err", 32'(status_err), 0);
    pulse_stop();
    check("cont_stop_idle", 32'(status_busy), 0);

    // short line: 751 pixels against width 752
    cfg_width = 11'd752;
    cfg_height = 10'd1;
    pulse_start(1'b0);
    clear_stats();
    send_line(751, 1'b1);
    idle(2);
    check("short_err", 32'(status_err), 3'b001);
    check("short_frame_done", 32'(fd_total - fd0), 1);
    idle(4);
    check("short_err_sticky", 32'(status_err), 3'b001);
    pulse_start(1'b0);
    check("short_err_cleared", 32'(status_err), 0);
    check("short_rearm_busy", 32'(status_busy), 1);
    send_line(752, 1'b1);
    idle(2);
    check("good_err", 32'(status_err), 0);
    check("good_busy", 32'(status_busy), 0);

    // long line: 5 pixels against width 4
    cfg_width = 11'd4;
    pulse_start(1'b0);
    send_line(5, 1'b1);
    idle(2);
    check("long_err", 32'(status_err), 3'b010);

    // early SOF at row 1 of a 3-line frame
    cfg_height = 10'd3;
    pulse_start(1'b0);
    clear_stats();
    send_line(4, 1'b1);
    send_line(4, 1'b1);
    idle(2);
    check("early_err", 32'(status_err), 3'b100);
    check("early_no_done", 32'(fd_total - fd0), 0);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    idle(2);
    check("early_next_done", 32'(fd_total - fd0), 1);
    check("early_fwd_count", 32'(fwd_count), 16);
    check("early_busy", 32'(status_busy), 0);

    // downstream back-pressure toggling every cycle
    cfg_width = 11'd752;
    cfg_height = 10'd2;
    pulse_start(1'b0);
    clear_stats();
    toggle = 1'b1;
    mirror_chk = 1'b1;
    send_frame(752, 2);
    toggle = 1'b0;
    mirror_chk = 1'b0;
    idle(2);
    check("bp_fwd_count", 32'(fwd_count), 1504);
    check("bp_seq", 32'(seq_err), 0);
    check("bp_mirror", 32'(mirror_err), 0);
    check("bp_frame_done", 32'(fd_total - fd0), 1);
    check("bp_err", 32'(status_err), 0);

    // stop mid-frame in continuous mode
    cfg_width = 11'd4;
    cfg_height = 10'd3;
    pulse_start(1'b1);
    clear_stats();
    send_line(4, 1'b1);
    pulse_stop();
    check("stop_still_busy", 32'(status_busy), 1);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    idle(2);
    check("stop_frame_done", 32'(fd_total - fd0), 1);
    check("stop_idle", 32'(status_busy), 0);
    send_frame(4, 3);
    idle(2);
    check("stop_fwd_count", 32'(fwd_count), 12);

    // asynchronous reset in the middle of a line
    pulse_start(1'b1);
    send_beat(16'd1, 1'b1, 1'b0);
    send_beat(16'd2, 1'b0, 1'b0);
    @(negedge axi4sclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'd3;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("arst_pre_tvalid", 32'(m_axis_tvalid), 1);
    axi4s_reset = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_axis_tvalid), 0);
    check("arst_busy", 32'(status_busy), 0);
    check("arst_s_tready", 32'(s_axis_tready), 1);
    @(negedge axi4sclk);
    axi4s_reset = 1'b0;
    s_axis_tvalid = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mt9v034_frame_ctrl.md
Name: mt9v034_frame_ctrl

Overview:
- Frame-level capture controller on the AXI4-Stream output of the MT9V034 camera input block, in the axi4sclk domain, upstream of VDMA.
- Software arms single-shot or continuous capture. The block forwards only whole frames starting at an SOF (tuser) beat and discards the stream while idle.
- Checks line length and line count against the configured geometry and reports frame-done and sticky error status.

Parameters:
- DATA_WIDTH, 16, tdata width in bits.
- COL_BITS, 11, width of cfg_width and the column counter (maximum 2047 pixels per line).
- ROW_BITS, 10, width of cfg_height and the row counter (maximum 1023 lines).

Ports:
- axi4sclk  in  1  stream clock; all logic is on rising edge.
- axi4s_reset  in  1  asynchronous, active-high reset.
- ctrl_start  in  1  one-cycle pulse; arms capture and clears sticky errors.
- ctrl_continuous  in  1  sampled at ctrl_start; 1 = continuous, 0 = single frame.
- ctrl_stop  in  1  one-cycle pulse; stop at the next frame boundary.
- cfg_width  in  COL_BITS  expected pixels per line (752 typical).
- cfg_height  in  ROW_BITS  expected lines per frame (480 typical).
- s_axis_tdata  in  DATA_WIDTH  pixel from the camera input block.
- s_axis_tvalid, s_axis_tuser, s_axis_tlast  in  1 each  input stream sideband.
- s_axis_tready  out  1  input stream ready.
- m_axis_tdata  out  DATA_WIDTH  forwarded pixel.
- m_axis_tvalid, m_axis_tuser, m_axis_tlast  out  1 each  output stream sideband.
- m_axis_tready  in  1  output stream ready.
- status_busy  out  1  high in any state other than IDLE.
- status_frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.
- status_err  out  3  sticky flags: [0] short line, [1] long line, [2] early SOF (short frame).

Behaviour:
- Reset values:
  - state = IDLE; counters = 0; status_err = 0; status_frame_done = 0; status_busy = 0; m_axis_tvalid = 0.
  - s_axis_tready = 1, so upstream drains during reset and idle.
- Datapath:
  - tdata, tuser and tlast pass through combinationally with zero latency and no buffering.
  - A beat is accepted when s_axis_tvalid & s_axis_tready.
- FSM states:
  - IDLE:
    - s_axis_tready = 1; m_axis_tvalid = 0; input beats are discarded.
    - ctrl_start → WAIT_SOF.
  - WAIT_SOF:
    - A beat with tuser = 0 is discarded (s_axis_tready = 1).
    - A beat with tuser = 1 is forwarded (m_axis_tvalid = 1, s_axis_tready = m_axis_tready). On acceptance: state → PASS, col = 1, row = 0.
    - ctrl_stop → IDLE immediately.
  - PASS:
    - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready.
    - col increments per accepted beat.
    - On an accepted tlast beat:
      - col+1 < cfg_width sets err[0]; col+1 > cfg_width sets err[1].
      - col = 0; row increments.
    - Last line (row == cfg_height-1):
      - status_frame_done pulses the next cycle.
      - Next state: WAIT_SOF if continuous and no stop is pending, else IDLE.
    - A beat with tuser = 1 where col ≠ 0 or row ≠ 0:
      - Sets err[2] and is forwarded as the new frame's SOF.
      - Counters restart (col = 1, row = 0).
      - No frame_done is issued for the truncated frame.
    - col saturates at its maximum value; no wrap-around.
  - ctrl_stop during PASS latches stop_pending. The current frame completes, then state → IDLE and stop_pending clears.
- Simultaneous events:
  - ctrl_start and ctrl_stop in the same cycle: stop wins.
  - ctrl_start while busy: ignored, except that it clears err.
- Mid-operation reset: outputs return to reset values immediately (asynchronous). A downstream partial frame is not completed.
- cfg_width and cfg_height are sampled at every tlast. Software changes them only while IDLE.

Optional Feature:
- Macro: MT9V034_FRAME_CTRL_COUNTERS_EN.
- Defined:
  - Adds outputs frames_ok [31:0] and frames_err [31:0], both reset to 0 and cleared by ctrl_start.
  - On each frame_done, frames_ok increments if the frame had no error, else frames_err increments.
  - An early-SOF truncation increments frames_err.
  - Both counters wrap at 2^32.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mt9v034_pkg holds:
  - state enum (IDLE, WAIT_SOF, PASS);
  - error bit index constants;
  - DEFAULT_WIDTH = 752 and DEFAULT_HEIGHT = 480.
- Sub-module mt9v034_geom_check holds the col/row counters and error detection, driven by accept/tuser/tlast strobes. The FSM and handshake muxing stay in the top module.

Test Plan:
- Single shot, cfg 752x2, m_axis_tready = 1, two frames sent → exactly 1504 beats forwarded (first beat tuser = 1); one frame_done pulse; status_busy = 0 afterwards; err = 000.
- Continuous mode, start arrives mid-frame → beats before the next tuser are discarded; two full frames forwarded; two frame_done pulses.
- Line with 751 pixels then tlast → err[0] = 1 and stays set; next ctrl_start clears it.
- New tuser arriving at row 1 of a 3-line frame → err[2] = 1; no frame_done; the following complete frame yields frame_done.
- m_axis_tready toggled at 50% during PASS → forwarded data sequence is 1..752 per line, with no drops or duplicates; s_axis_tready mirrors m_axis_tready.
- ctrl_stop mid-frame in continuous mode → current frame completes with frame_done, then IDLE; asserting axi4s_reset mid-line → m_axis_tvalid = 0 in the same cycle.
